popcount_pipe: RTL and testbench
================================

# popcount_pipe

Pipelined, parametrised population-count engine for wide words, the streaming successor to the combinational 128-bit popcount tree. Each accepted word's set bits are counted through a 3-stage registered adder tree with valid/ready handshakes on both sides. It sits between a word-stream producer and any consumer of bit-density statistics. Two modes are supported: per-word count, and burst accumulation with a saturating accumulator.

## Interface
Parameters:
- DATA_W, 128, input word width; multiple of 16, ≥16. Lane count L = DATA_W/16.
- CNT_W, $clog2(DATA_W+1), width of a single-word count (8 for 128).
- ACC_W, 16, accumulator/result width; must be ≥ CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready at a clk edge.
- in_data  in  DATA_W  word to count.
- in_mode  in  1  0 = per-word result, 1 = accumulate into burst.
- in_last  in  1  mode 1 only: final beat of the burst.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  count, zero-extended, or saturated burst total.
- out_last  out  1  1 on every result: mode-0 word or burst end.
- out_sat  out  1  burst total clamped to 2^ACC_W−1.

## Operation
- S1 registers L lane counts, 5 bits each, holding popcount of in_data[16i+15:16i]. in_mode and in_last travel alongside.
- S2 registers the word count: sum of lanes, CNT_W bits.
- S3 is the output register plus the accumulator acc, ACC_W bits.
- Behaviour when an S2 beat advances:
  - Mode 0: out_data = zero-extended count; out_last = 1; out_sat = 0. acc is untouched, so a mode-0 word inside an open burst is emitted independently.
  - Mode 1, in_last = 0: acc ← sat(acc + count); sticky sat_flag is set if clamped. No output is produced.
  - Mode 1, in_last = 1: out_data = sat(acc + count); out_sat = sat_flag OR clamp on this add; out_last = 1. Then acc ← 0 and sat_flag ← 0.
- sat(x) = min(x, 2^ACC_W−1). The internal sum is ACC_W+1 bits.
- Reset mid-operation: all stage valids, acc, and sat_flag clear. A partial burst is discarded.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, out_sat = 0.

## Timing
- Global advance enable: en = !out_valid | out_ready. When en = 0 every stage, acc included, holds its value.
- in_ready = en. This is a combinational path from out_ready and out_valid. No other combinational input→output path exists.
- Latency: a beat accepted at edge N is in S1 at N, S2 at N+1, and S3 at N+2. out_valid is high from edge N+2 until the result is taken.
- Throughput: 1 beat per cycle when out_ready is held high.
- Mode-1 non-last beats do not raise out_valid. They leave bubbles at the output.
- out_data, out_last, and out_sat stay stable while out_valid & !out_ready.
- Bubbles (invalid stages) advance normally and never update acc.
- Simultaneous out_ready and a new beat at S2: the old result is taken and the new one loads at the same edge.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle. Required response: all outputs zero immediately and in_ready = 1 after release.
- Mode 0, out_ready = 1, back-to-back words all-ones, all-zeros, then 0xAAAA…: out_data = 128, 0, 64 on consecutive cycles, first at acceptance edge + 2, out_last = 1 each.
- Mode 1 burst of 4 all-ones words, in_last on the 4th: exactly one result, out_data = 512, out_last = 1, out_sat = 0, with no output for beats 1–3.
- Back-pressure: 3 mode-0 beats in flight, then out_ready = 0 for 5 cycles. Required response: in_ready = 0, out_data held, and after release all 3 counts emerge in order with none lost.
- Saturation with ACC_W = 9: burst of 5 all-ones words (total 640). Required response: out_data = 511, out_sat = 1. A following 1-word burst of 0x0F gives out_data = 4, out_sat = 0.
- Mode-1 beats 1 and 2 at 0xFF each, then a mode-0 word 0x1, then last beat 0x3: outputs are 1 (mode 0) then 18 (burst). Repeat with rst_n pulsed after beat 2: the next burst total excludes the pre-reset beats.

Source files
------------

// File: rtl/popcount_pipe.sv
// rtl/popcount_pipe.sv - 3-stage pipelined popcount with per-word and saturating burst modes
module popcount_pipe #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = $clog2(DATA_W + 1),
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              out_sat
);

    localparam int L = DATA_W / 16;

    logic             en;
    logic [4:0]       lane_cnt [L];
    logic             s1_valid, s1_mode, s1_last;
    logic [4:0]       s1_lanes [L];
    logic [CNT_W-1:0] word_cnt;
    logic             s2_valid, s2_mode, s2_last;
    logic [CNT_W-1:0] s2_cnt;
    logic [ACC_W-1:0] acc;
    logic             sat_flag;
    logic [ACC_W:0]   sum;
    logic             clamp;
    logic [ACC_W-1:0] sat_val;

    // One global enable: the whole pipe, accumulator included, freezes on a stalled result
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        for (int i = 0; i < L; i++) begin
            lane_cnt[i] = '0;
            for (int b = 0; b < 16; b++) begin
                lane_cnt[i] = lane_cnt[i] + 5'(in_data[16*i+b]);
            end
        end
    end

    always_comb begin
        word_cnt = '0;
        for (int i = 0; i < L; i++) begin
            word_cnt = word_cnt + CNT_W'(s1_lanes[i]);
        end
    end

    // One extra bit of headroom exposes overflow of acc + count
    assign sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(s2_cnt);
    assign clamp   = sum[ACC_W];
    assign sat_val = clamp ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < L; i++) s1_lanes[i] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_last  <= in_last;
            for (int i = 0; i < L; i++) s1_lanes[i] <= lane_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_last  <= 1'b0;
            s2_cnt   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_last  <= s1_last;
            s2_cnt   <= word_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            if (s2_valid) begin
                if (!s2_mode) begin
                    out_valid <= 1'b1;
                    out_data  <= ACC_W'(s2_cnt);
                    out_last  <= 1'b1;
                    out_sat   <= 1'b0;
                end else if (!s2_last) begin
                    acc      <= sat_val;
                    sat_flag <= sat_flag || clamp;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= sat_val;
                    out_last  <= 1'b1;
                    out_sat   <= sat_flag || clamp;
                    acc       <= '0;
                    sat_flag  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// tb/tb_popcount_pipe.sv - directed self-checking bench for popcount_pipe (ACC_W 16 and 9)
module tb_popcount_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, out_last, out_sat;
    logic [15:0]  out_data;
    logic         in_ready9, out_valid9, out_last9, out_sat9;
    logic [8:0]   out_data9;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_edge;

    int q_data[$];
    int q_last[$];
    int q_sat[$];
    int q_cyc[$];
    int q9_data[$];
    int q9_sat[$];

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] ALT  = {32{4'hA}};

    popcount_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat)
    );

    popcount_pipe #(.ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9),
        .out_last(out_last9), .out_sat(out_sat9)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_last.push_back(int'(out_last));
            q_sat.push_back(int'(out_sat));
            q_cyc.push_back(cyc);
        end
        if (out_valid9 && out_ready) begin
            q9_data.push_back(int'(out_data9));
            q9_sat.push_back(int'(out_sat9));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic m, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        @(posedge clk);
        #1;
        acc_edge = cyc;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_last.delete(); q_sat.delete(); q_cyc.delete();
        q9_data.delete(); q9_sat.delete();
    endtask

    initial begin
        int e0;

        // Reset state
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        #20;
        rst_n = 1'b1;
        idle(2);
        check("rst_in_ready", int'(in_ready), 1);

        // Mode 0 back-to-back
        clear_q();
        beat(ONES, 1'b0, 1'b0);
        e0 = acc_edge;
        beat('0, 1'b0, 1'b0);
        beat(ALT, 1'b0, 1'b0);
        idle(6);
        check("m0_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("m0_ones", q_data[0], 128);
            check("m0_zero", q_data[1], 0);
            check("m0_alt", q_data[2], 64);
            check("m0_last", q_last[0] + q_last[1] + q_last[2], 3);
            check("m0_latency", q_cyc[0] - e0, 2);
            check("m0_consec", q_cyc[2] - q_cyc[0], 2);
        end

        // Mode 1 burst of 4 all-ones
        clear_q();
        beat(ONES, 1'b1, 1'b0);
        beat(ONES, 1'b1, 1'b0);
        beat(ONES, 1'b1, 1'b0);
        check("burst_no_early_out", q_data.size(), 0);
        beat(ONES, 1'b1, 1'b1);
        idle(6);
        check("burst_count", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("burst_data", q_data[0], 512);
            check("burst_last", q_last[0], 1);
            check("burst_sat", q_sat[0], 0);
        end
        if (q9_data.size() == 1) begin
            check("burst9_data", q9_data[0], 511);
            check("burst9_sat", q9_sat[0], 1);
        end else check("burst9_count", q9_data.size(), 1);

        // Back-pressure with 3 beats in flight
        clear_q();
        beat({112'd0, 16'hFFFF}, 1'b0, 1'b0);
        beat(128'h3, 1'b0, 1'b0);
        beat(128'h7, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        check("bp_first_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_hold_data", int'(out_data), 16);
        end
        check("bp_none_taken", q_data.size(), 0);
        out_ready = 1'b1;
        idle(6);
        check("bp_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("bp_d0", q_data[0], 16);
            check("bp_d1", q_data[1], 2);
            check("bp_d2", q_data[2], 3);
        end

        // Saturation at ACC_W = 9
        clear_q();
        for (int i = 0; i < 5; i++) beat(ONES, 1'b1, i == 4);
        beat(128'h0F, 1'b1, 1'b1);
        idle(6);
        check("sat9_count", q9_data.size(), 2);
        if (q9_data.size() == 2) begin
            check("sat9_total", q9_data[0], 511);
            check("sat9_flag", q9_sat[0], 1);
            check("sat9_next", q9_data[1], 4);
            check("sat9_next_flag", q9_sat[1], 0);
        end
        check("sat16_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("sat16_total", q_data[0], 640);
            check("sat16_flag", q_sat[0], 0);
        end

        // Mode-0 word inside an open burst
        clear_q();
        beat(128'hFF, 1'b1, 1'b0);
        beat(128'hFF, 1'b1, 1'b0);
        beat(128'h1, 1'b0, 1'b0);
        beat(128'h3, 1'b1, 1'b1);
        idle(6);
        check("mix_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("mix_word", q_data[0], 1);
            check("mix_burst", q_data[1], 18);
        end

        // Same, with an asynchronous reset after beat 2
        clear_q();
        beat(128'hFF, 1'b1, 1'b0);
        beat(128'hFF, 1'b1, 1'b0);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_last", int'(out_last), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("mid_rst_in_ready", int'(in_ready), 1);
        beat(128'h1, 1'b0, 1'b0);
        beat(128'h3, 1'b1, 1'b1);
        idle(6);
        check("post_rst_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("post_rst_word", q_data[0], 1);
            check("post_rst_burst", q_data[1], 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
